vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_scanout.sv | 115 +++++++++++
 tb/tb_vga_scanout.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals/widths and the raw timing-flag record.
package vga_pkg;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned COLOR_BITS_DEF = 4;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned X_W_DEF = cnt_width(H_TOTAL_DEF);
  localparam int unsigned Y_W_DEF = cnt_width(V_TOTAL_DEF);

  localparam bit          HSYNC_POL_DEF  = 1'b0;
  localparam bit          VSYNC_POL_DEF  = 1'b0;
  localparam int unsigned CLK_DIV_DEF    = 2;
  localparam int unsigned PIPE_DEPTH_DEF = 2;

  // Sync fields hold "inside the pulse window", not the pin level.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } raw_t;

endpackage

// File: rtl/vga_delay_line.sv
// Tick-gated shift register; DEPTH=0 is a straight wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctl;
      always_comb begin
        dout       = din;
        unused_ctl = clk ^ rst ^ clr ^ adv;
      end
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (adv) begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      always_comb dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator: pixel-tick divider, x/y counters, sync/active decode,
// pixel-source latency compensation and registered pin outputs.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned COLOR_BITS = COLOR_BITS_DEF,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter bit          HSYNC_POL  = HSYNC_POL_DEF,
  parameter bit          VSYNC_POL  = VSYNC_POL_DEF,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = cnt_width(H_TOTAL),
  localparam int unsigned YW        = cnt_width(V_TOTAL)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    en,
  input  logic [3*COLOR_BITS-1:0] pix_rgb,
  output logic [XW-1:0]           x,
  output logic [YW-1:0]           y,
  output logic                    tick,
  output logic                    line_start,
  output logic                    frame_start,
  output logic                    hsync,
  output logic                    vsync,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    de
);

  localparam int unsigned DW       = cnt_width(CLK_DIV);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

  logic [DW-1:0] div;
  logic          clear;
  raw_t          raw_now;
  raw_t          raw_dly;

  always_comb begin
    clear       = wb_rst_i || !en;
    tick        = !clear && (div == DIV_LAST);
    line_start  = tick && (x == '0);
    frame_start = line_start && (y == '0);
  end

  always_ff @(posedge wb_clk_i) begin
    if (clear || div == DIV_LAST) div <= '0;
    else                          div <= div + 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (clear) begin
      x <= '0;
      y <= '0;
    end else if (tick) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Compares are done at 32 bits so window ends equal to the total never truncate.
  always_comb begin
    raw_now.active = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
    raw_now.hsync  = (32'(x) >= HS_START) && (32'(x) < HS_END);
    raw_now.vsync  = (32'(y) >= VS_START) && (32'(y) < VS_END);
  end

  vga_delay_line #(
    .WIDTH($bits(raw_t)),
    .DEPTH(PIPE_DEPTH)
  ) u_delay (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (!en),
    .adv (tick),
    .din (raw_now),
    .dout(raw_dly)
  );

  always_ff @(posedge wb_clk_i) begin
    if (clear) begin
      de                 <= 1'b0;
      hsync              <= !HSYNC_POL;
      vsync              <= !VSYNC_POL;
      {red, green, blue} <= '0;
    end else if (tick) begin
      de                 <= raw_dly.active;
      hsync              <= raw_dly.hsync ? HSYNC_POL : !HSYNC_POL;
      vsync              <= raw_dly.vsync ? VSYNC_POL : !VSYNC_POL;
      {red, green, blue} <= raw_dly.active ? pix_rgb : '0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench: five vga_scanout configurations on a tiny 8x6 raster,
// directed vectors plus randomized en/reset/pixel stimulus against a cycle-count model.
module tb_vga_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int NI = 5;
  localparam int NTBL = 11;

  function automatic int f_div(input int i);
    case (i)
      1:       return 3;
      4:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int f_pipe(input int i);
    case (i)
      2:       return 2;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit f_hpol(input int i);
    return (i == 3);
  endfunction

  function automatic bit f_vpol(input int i);
    return (i == 3) || (i == 4);
  endfunction

  typedef struct {
    int cyc;
    int x;
    int y;
    bit fs;
    bit ls;
    bit hs;
    bit vs;
    bit de;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] pix;

  logic [2:0] x_o [NI];
  logic [2:0] y_o [NI];
  logic       tk  [NI];
  logic       ls  [NI];
  logic       fs  [NI];
  logic       hs  [NI];
  logic       vs  [NI];
  logic       de_o[NI];
  logic [3:0] r_o [NI];
  logic [3:0] g_o [NI];
  logic [3:0] b_o [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    vga_scanout #(
      .COLOR_BITS(4),
      .H_ACTIVE  (HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE  (VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL (f_hpol(gi)),
      .VSYNC_POL (f_vpol(gi)),
      .CLK_DIV   (f_div(gi)),
      .PIPE_DEPTH(f_pipe(gi))
    ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .en         (en),
      .pix_rgb    (pix),
      .x          (x_o[gi]),
      .y          (y_o[gi]),
      .tick       (tk[gi]),
      .line_start (ls[gi]),
      .frame_start(fs[gi]),
      .hsync      (hs[gi]),
      .vsync      (vs[gi]),
      .red        (r_o[gi]),
      .green      (g_o[gi]),
      .blue       (b_o[gi]),
      .de         (de_o[gi])
    );
  end

  // Model state: c = enabled, non-reset cycles since the last clear.
  int          c;
  bit          live;
  logic [11:0] pix_by_c [8192];
  int          n_cmp;
  int          n_bad;
  vec_t        tbl [NTBL];

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NI; i++) begin
      int d, p, t, k, kx, ky, xe, ye, rgb_e;
      bit tk_e, act, hw, vw, hp, vp;
      d = f_div(i); p = f_pipe(i); hp = f_hpol(i); vp = f_vpol(i);
      t = c / d;
      xe = t % HT;
      ye = (t / HT) % VT;
      tk_e = en && !rst && (c % d == d - 1);
      act = 1'b0; hw = 1'b0; vw = 1'b0; rgb_e = 0;
      if (t >= p + 1) begin
        k  = t - 1 - p;
        kx = k % HT;
        ky = (k / HT) % VT;
        act = (kx < HA) && (ky < VA);
        hw  = (kx >= HA + HF) && (kx < HA + HF + HS);
        vw  = (ky >= VA + VF) && (ky < VA + VF + VS);
        if (act) rgb_e = int'(pix_by_c[(t - 1) * d + d - 1]);
      end
      chk("x",           i, int'(x_o[i]),  xe);
      chk("y",           i, int'(y_o[i]),  ye);
      chk("tick",        i, int'(tk[i]),   int'(tk_e));
      chk("line_start",  i, int'(ls[i]),   int'(tk_e && xe == 0));
      chk("frame_start", i, int'(fs[i]),   int'(tk_e && xe == 0 && ye == 0));
      chk("de",          i, int'(de_o[i]), int'(act));
      chk("hsync",       i, int'(hs[i]),   int'(hw ? hp : !hp));
      chk("vsync",       i, int'(vs[i]),   int'(vw ? vp : !vp));
      chk("rgb",         i, int'({r_o[i], g_o[i], b_o[i]}), rgb_e);
    end
  endtask

  task automatic apply(input bit r, input bit e, input logic [11:0] p);
    rst = r;
    en  = e;
    pix = p;
  endtask

  task automatic settle();
    @(negedge clk);
    if (live) check_model();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (rst || !en) begin
      c = 0;
    end else begin
      pix_by_c[c] = pix;
      c++;
    end
    live = 1'b1;
    #1;
  endtask

  initial begin
    int ti, btk;
    n_cmp = 0; n_bad = 0; c = 0; live = 1'b0;
    // {cycle after reset, x, y, frame_start, line_start, hsync, vsync, de} for inst0
    tbl = '{
      '{0,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1,  1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{5,  5, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{6,  6, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{7,  7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{8,  0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{9,  1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
      '{33, 1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{40, 0, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{41, 1, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{48, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}
    };

    // Reset with en also high: reset must win.
    for (int n = 0; n < 3; n++) begin
      apply(1'b1, 1'b1, 12'($urandom));
      settle();
      finish_cycle();
    end

    // Directed frame on inst0, line timing on inst1 (CLK_DIV=3).
    ti = 0; btk = 0;
    for (int cyc = 0; cyc <= 48; cyc++) begin
      apply(1'b0, 1'b1, 12'($urandom));
      settle();
      if (ti < NTBL && tbl[ti].cyc == cyc) begin
        chk("tbl_x",  0, int'(x_o[0]),  tbl[ti].x);
        chk("tbl_y",  0, int'(y_o[0]),  tbl[ti].y);
        chk("tbl_fs", 0, int'(fs[0]),   int'(tbl[ti].fs));
        chk("tbl_ls", 0, int'(ls[0]),   int'(tbl[ti].ls));
        chk("tbl_hs", 0, int'(hs[0]),   int'(tbl[ti].hs));
        chk("tbl_vs", 0, int'(vs[0]),   int'(tbl[ti].vs));
        chk("tbl_de", 0, int'(de_o[0]), int'(tbl[ti].de));
        ti++;
      end
      if (cyc < 24 && tk[1]) btk++;
      if (cyc == 24) begin
        chk("div3_line_x", 1, int'(x_o[1]), 0);
        chk("div3_line_y", 1, int'(y_o[1]), 1);
      end
      finish_cycle();
    end
    chk("tbl_rows_hit", 0, ti, NTBL);
    chk("div3_ticks_per_line", 1, btk, 8);

    // Drop en at x=3, y=2, then re-raise with a held pixel value.
    apply(1'b0, 1'b0, 12'h000); settle(); finish_cycle();
    for (int n = 0; n < 19; n++) begin
      apply(1'b0, 1'b1, 12'($urandom)); settle(); finish_cycle();
    end
    apply(1'b0, 1'b0, 12'($urandom));
    settle();
    chk("drop_at_x", 0, int'(x_o[0]), 3);
    chk("drop_at_y", 0, int'(y_o[0]), 2);
    chk("drop_no_tick", 0, int'(tk[0]), 0);
    finish_cycle();
    apply(1'b0, 1'b0, 12'($urandom));
    settle();
    chk("idle_x",   0, int'(x_o[0]),  0);
    chk("idle_y",   0, int'(y_o[0]),  0);
    chk("idle_de",  0, int'(de_o[0]), 0);
    chk("idle_hs",  0, int'(hs[0]),   1);
    chk("idle_vs",  0, int'(vs[0]),   1);
    chk("idle_hs",  3, int'(hs[3]),   0);
    chk("idle_rgb", 0, int'({r_o[0], g_o[0], b_o[0]}), 0);
    finish_cycle();

    for (int cyc = 0; cyc <= 12; cyc++) begin
      apply(1'b0, 1'b1, 12'hABC);
      settle();
      if (cyc == 0) chk("restart_fs", 0, int'(fs[0]), 1);
      if (cyc < 3)  chk("pipe_de_early", 2, int'(de_o[2]), 0);
      if (cyc == 3) begin
        chk("pipe_de_first", 2, int'(de_o[2]), 1);
        chk("pipe_rgb_first", 2, int'({r_o[2], g_o[2], b_o[2]}), 12'hABC);
      end
      if (de_o[2] == 1'b0) chk("pipe_rgb_blank", 2, int'({r_o[2], g_o[2], b_o[2]}), 0);
      finish_cycle();
    end

    // Mid-frame reset with en held high; second reset cycle shows reset values.
    for (int n = 0; n < 2; n++) begin
      apply(1'b1, 1'b1, 12'($urandom)); settle(); finish_cycle();
    end
    apply(1'b1, 1'b1, 12'($urandom));
    settle();
    chk("rst_x",    0, int'(x_o[0]),  0);
    chk("rst_tick", 0, int'(tk[0]),   0);
    chk("rst_fs",   0, int'(fs[0]),   0);
    chk("rst_de",   0, int'(de_o[0]), 0);
    chk("rst_hs",   0, int'(hs[0]),   1);
    chk("rst_vs",   0, int'(vs[0]),   1);
    chk("rst_hs",   3, int'(hs[3]),   0);
    finish_cycle();

    // Randomized en drops, occasional resets, random pixels.
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom % 256) == 0, ($urandom % 64) != 0, 12'($urandom));
      settle();
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
